// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one-hot active-low anode scan with per-digit
// blanking, decimal point, PWM brightness and a dark guard at the start of every slot.
module display_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 4,
    parameter int BRIGHT_W    = 4,
    parameter int IDX_W       = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [6:0]              SEG,
    output logic                    DP,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_tick
);

    // Prescaler is at least BRIGHT_W wide so the PWM compare always has its low bits.
    localparam int PW_RAW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int CW     = (PW_RAW > BRIGHT_W) ? PW_RAW : BRIGHT_W;
    localparam logic [CW-1:0]    PRESC_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]    BLANK_END  = CW'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [CW-1:0]         r_presc;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_frame;
    logic [3:0]            r_lat_digit;
    logic                  r_lat_dp;
    logic                  r_lat_blank;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;
    logic                  r_dp;

    logic                  w_presc_wrap;
    logic                  w_slot_start;
    logic [3:0]            w_cur_digit;
    logic                  w_cur_dp;
    logic                  w_cur_blank;
    logic                  w_pwm_on;
    logic                  w_lit;
    logic [NUM_DIGITS-1:0] w_an;
    logic [6:0]            w_seg_dec;

    assign w_presc_wrap = (r_presc == PRESC_LAST);
    assign w_slot_start = (r_presc == '0);

    // On the slot's first cycle the latch is still loading, so look through to the inputs.
    assign w_cur_digit = w_slot_start ? digits[{r_idx, 2'b00} +: 4] : r_lat_digit;
    assign w_cur_dp    = w_slot_start ? dp_mask[r_idx]              : r_lat_dp;
    assign w_cur_blank = w_slot_start ? blank_mask[r_idx]           : r_lat_blank;

    assign w_pwm_on = (brightness == '1) || (r_presc[BRIGHT_W-1:0] < brightness);
    assign w_lit    = en && !w_cur_blank && (r_presc >= BLANK_END) && w_pwm_on;

    // Digit 0 is the leftmost, i.e. the most significant anode bit.
    always_comb begin
        w_an = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_lit && (r_idx == IDX_W'(NUM_DIGITS - 1 - i))) begin
                w_an[i] = 1'b0;
            end
        end
    end

    always_comb begin
        w_seg_dec = 7'h7F;
        case (w_cur_digit)
            4'h0: w_seg_dec = 7'b1000000;
            4'h1: w_seg_dec = 7'b1111001;
            4'h2: w_seg_dec = 7'b0100100;
            4'h3: w_seg_dec = 7'b0110000;
            4'h4: w_seg_dec = 7'b0011001;
            4'h5: w_seg_dec = 7'b0010010;
            4'h6: w_seg_dec = 7'b0000010;
            4'h7: w_seg_dec = 7'b1111000;
            4'h8: w_seg_dec = 7'b0000000;
            4'h9: w_seg_dec = 7'b0010000;
            4'hA: w_seg_dec = 7'b0001000;
            4'hB: w_seg_dec = 7'b0000011;
            4'hC: w_seg_dec = 7'b1000110;
            4'hD: w_seg_dec = 7'b0100001;
            4'hE: w_seg_dec = 7'b0000110;
            4'hF: w_seg_dec = 7'b0001110;
            default: w_seg_dec = 7'h7F;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc     <= '0;
            r_idx       <= '0;
            r_frame     <= 1'b0;
            r_lat_digit <= 4'h0;
            r_lat_dp    <= 1'b0;
            r_lat_blank <= 1'b1;
            r_an        <= '1;
            r_seg       <= 7'h7F;
            r_dp        <= 1'b1;
        end else begin
            r_frame <= 1'b0;
            if (en) begin
                if (w_presc_wrap) begin
                    r_presc <= '0;
                    r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                    r_frame <= (r_idx == IDX_LAST);
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
                if (w_slot_start) begin
                    r_lat_digit <= w_cur_digit;
                    r_lat_dp    <= w_cur_dp;
                    r_lat_blank <= w_cur_blank;
                end
            end
            r_an  <= w_an;
            r_seg <= w_lit ? w_seg_dec : 7'h7F;
            r_dp  <= w_lit ? ~w_cur_dp : 1'b1;
        end
    end

    assign AN         = r_an;
    assign SEG        = r_seg;
    assign DP         = r_dp;
    assign digit_idx  = r_idx;
    assign frame_tick = r_frame;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with 4 digits, 8-cycle slots, 1 guard cycle, 2-bit brightness.
module tb_display_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 1;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [15:0]   digits;
    logic [3:0]    dp_mask;
    logic [3:0]    blank_mask;
    logic [1:0]    brightness;
    logic [3:0]    AN;
    logic [6:0]    SEG;
    logic          DP;
    logic [1:0]    digit_idx;
    logic          frame_tick;

    int n_tests = 0;
    int n_fail  = 0;
    bit run_chk = 1'b0;

    logic [3:0] an_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [6:0] hex7 [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .BLANK_CYC  (BC),
        .BRIGHT_W   (BW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .digits    (digits),
        .dp_mask   (dp_mask),
        .blank_mask(blank_mask),
        .brightness(brightness),
        .AN        (AN),
        .SEG       (SEG),
        .DP        (DP),
        .digit_idx (digit_idx),
        .frame_tick(frame_tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_an"},  AN,  4'hF);
        chk({tag, "_seg"}, SEG, 7'h7F);
        chk({tag, "_dp"},  DP,  1'b1);
    endtask

    // Walks k = k0..k1 edges after a slot-0/prescaler-0 start. The output seen after edge k
    // reflects prescaler (k-1)%8 of slot ((k-1)/8)%4; nib0 is the value latched for digit 0.
    task automatic scan(input string tag, input int k0, input int k1, input logic [3:0] nib0);
        for (int k = k0; k <= k1; k++) begin
            int  pp;
            int  sl;
            bit  pwm;
            bit  lit;
            logic [3:0] nib;
            tick();
            pp  = (k - 1) % RD;
            sl  = ((k - 1) / RD) % ND;
            pwm = (brightness == 2'b11) || ((pp % 4) < int'(brightness));
            lit = (pp >= BC) && !blank_mask[sl] && pwm;
            nib = (sl == 0) ? nib0 : digits[sl*4 +: 4];
            if (lit) begin
                chk($sformatf("%s_an_k%0d", tag, k),  AN,  an_tab[sl]);
                chk($sformatf("%s_seg_k%0d", tag, k), SEG, hex7[nib]);
                chk($sformatf("%s_dp_k%0d", tag, k),  DP,  dp_mask[sl] ? 1'b0 : 1'b1);
            end else begin
                chk_dark($sformatf("%s_k%0d", tag, k));
            end
            chk($sformatf("%s_idx_k%0d", tag, k),   digit_idx,  (k / RD) % ND);
            chk($sformatf("%s_frame_k%0d", tag, k), frame_tick, (k % (RD*ND) == 0) ? 1 : 0);
        end
    endtask

    always @(negedge clk) begin
        if (run_chk) chk("an_onehot", ($countones(~AN) <= 1) ? 32'd1 : 32'd0, 32'd1);
    end

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        digits     = 16'h4321;
        dp_mask    = 4'b0000;
        blank_mask = 4'b0000;
        brightness = 2'b11;

        // reset held three cycles with en high
        for (int i = 0; i < 3; i++) begin
            tick();
            run_chk = 1'b1;
            chk_dark("rst");
            chk("rst_idx",   digit_idx,  2'd0);
            chk("rst_frame", frame_tick, 1'b0);
        end
        rst = 1'b0;

        // full-bright scan: first cycle after release is the dark guard of slot 0
        scan("s2", 1, 32, digits[3:0]);

        // blanking of digit 1 (AN bit 2), DP on digit 0, hex E on digit 3
        blank_mask = 4'b0010;
        dp_mask    = 4'b0001;
        digits     = 16'hE321;
        scan("s3", 1, 32, digits[3:0]);

        // brightness 1: a single lit cycle at prescaler 4 per slot
        blank_mask = 4'b0000;
        dp_mask    = 4'b0000;
        digits     = 16'h4321;
        brightness = 2'b01;
        scan("s4a", 1, 32, digits[3:0]);

        brightness = 2'b00;
        scan("s4b", 1, 64, digits[3:0]);

        // mid-slot digit change is ignored until the next digit-0 slot
        brightness = 2'b11;
        scan("s5a", 1, 3, 4'h1);
        digits = 16'h4328;
        scan("s5b", 4, 32, 4'h1);
        scan("s5c", 33, 40, 4'h8);

        // now at slot 1, prescaler 0; move to slot 2, prescaler 5
        for (int i = 0; i < 13; i++) tick();
        chk("s6_idx_pre", digit_idx, 2'd2);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_dark($sformatf("s6_off%0d", i));
            chk("s6_off_idx",   digit_idx,  2'd2);
            chk("s6_off_frame", frame_tick, 1'b0);
        end
        en = 1'b1;
        // resumes at prescaler 5, 6, 7 of slot 2, then the guard of slot 3
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("s6_on%0d_an", i),  AN,  4'b1101);
            chk($sformatf("s6_on%0d_seg", i), SEG, hex7[3]);
            chk($sformatf("s6_on%0d_idx", i), digit_idx, (i == 3) ? 2'd3 : 2'd2);
        end
        tick();
        chk_dark("s6_guard3");
        chk("s6_guard3_idx", digit_idx, 2'd3);
        tick();
        chk("s6_slot3_an",  AN,  4'b1110);
        chk("s6_slot3_seg", SEG, hex7[4]);

        // reset mid-slot at idx 3
        rst = 1'b1;
        tick();
        chk_dark("s6_rst");
        chk("s6_rst_idx",   digit_idx,  2'd0);
        chk("s6_rst_frame", frame_tick, 1'b0);
        rst = 1'b0;
        scan("s6_post", 1, 32, digits[3:0]);

        run_chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
